// File: rtl/alu_shift_scheduler.sv
// -----------------------------------------------------------------------------
// alu_shift_scheduler
//
// Shares one 32-bit barrel shifter between two requesters (a, b). A round-robin
// arbiter picks one request while the block is idle. The selected operation is
// computed in one pass, or two passes for rotate. The result is then held until
// the consumer takes it.
//
// Op encoding: 00 SHL, 01 SHR (logical), 10 SHRA (arithmetic), 11 ROL.
// Right shifts reuse the left shifter by bit-reversing its input and output.
// Rotate-left is the OR of (in << n) and (in >> (32 - n)).
//
// Configuration macro:
//   ALU_SHIFT_SCHEDULER_ROTATE_EN  defined   -> op 11 is ROL, PASS2 present
//                                  undefined -> op 11 runs as SHL, no PASS2
//
// Ports:
//   clk                  system clock, rising edge
//   clr                  asynchronous active-low reset
//   req_{a,b}_valid      request present
//   req_{a,b}_ready      request accepted this cycle (IDLE only)
//   req_{a,b}_in [31:0]  operand
//   req_{a,b}_shift[5:0] shift count (>= 32 shifts everything out)
//   req_{a,b}_op [1:0]   operation
//   res_valid            result present (held until res_ready)
//   res_ready            consumer accepts the result
//   res_out [31:0]       result word
//   res_id               owner of the result, 0 = a, 1 = b
//   busy                 high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_shift_scheduler (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_a_valid,
   output logic        req_a_ready,
   input  logic [31:0] req_a_in,
   input  logic [5:0]  req_a_shift,
   input  logic [1:0]  req_a_op,
   input  logic        req_b_valid,
   output logic        req_b_ready,
   input  logic [31:0] req_b_in,
   input  logic [5:0]  req_b_shift,
   input  logic [1:0]  req_b_op,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_out,
   output logic        res_id,
   output logic        busy
);

   // state | meaning
   // ------+-----------------------------------------------------------
   // IDLE  | waiting for a request; the granted requester sees ready
   // PASS1 | first shifter pass; the final result for SHL/SHR/SHRA
   // PASS2 | rotate only: right-shift pass, ORed into the PASS1 partial
   // HOLD  | result valid, held stable until res_ready
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      HOLD  = 2'd3
   } state_t;
   localparam logic [1:0] OP_ROL = 2'b11;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      HOLD  = 2'd3
   } state_t;
`endif

   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHRA = 2'b10;

   state_t      state_q;
   logic        last_q;        // last granted requester, 0 = a, 1 = b
   logic [31:0] in_q;
   logic [5:0]  cnt_q;
   logic [1:0]  op_q;
   logic [31:0] res_out_q;
   logic        res_id_q;
   logic        res_valid_q;
   logic        busy_q;

   logic        grant_b_d;
   logic        idle_d;
   logic        accept_d;
   logic [31:0] in_d;
   logic [5:0]  shift_d;
   logic [1:0]  op_d;

   logic        second_pass_d;
   logic        is_rol_d;
   logic        neg_d;
   logic [31:0] sh_in_d;
   logic [5:0]  sh_cnt_d;
   logic [31:0] sh_out_d;
   logic [31:0] pass_d;

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Arbitration: when both requesters are valid, the one not granted last
   // wins. Otherwise the only valid requester wins.
   // ---------------------------------------------------------------------
   always_comb begin
      grant_b_d = 1'b0;
      if (req_a_valid && req_b_valid) begin
         grant_b_d = ~last_q;
      end else begin
         grant_b_d = req_b_valid;
      end
   end

   // Gating with clr keeps both readies low while reset is held.
   assign idle_d      = (state_q == IDLE) && clr;
   assign req_a_ready = idle_d && req_a_valid && !grant_b_d;
   assign req_b_ready = idle_d && req_b_valid &&  grant_b_d;
   assign accept_d    = req_a_ready || req_b_ready;

   always_comb begin
      in_d    = req_a_in;
      shift_d = req_a_shift;
      op_d    = req_a_op;
      if (grant_b_d) begin
         in_d    = req_b_in;
         shift_d = req_b_shift;
         op_d    = req_b_op;
      end
   end

   // ---------------------------------------------------------------------
   // Shared shifter. This is the only shift operator in the datapath.
   // Every pass steers its operand and count into it.
   // ---------------------------------------------------------------------
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
   assign second_pass_d = (state_q == PASS2);
   assign is_rol_d      = (op_q == OP_ROL);
`else
   assign second_pass_d = 1'b0;
   assign is_rol_d      = 1'b0;
`endif

   // SHRA of a negative operand is done as ~((~in) >> n). With this form,
   // the zero fill of the logical path becomes sign fill.
   assign neg_d = (op_q == OP_SHRA) && in_q[31] && !second_pass_d;

   always_comb begin
      sh_in_d  = in_q;
      sh_cnt_d = cnt_q;
      if (second_pass_d) begin
         // in >> (32 - n). The count is computed in 6 bits, so n = 0 gives
         // 32 and shifts everything out.
         sh_in_d  = rev32(in_q);
         sh_cnt_d = 6'd32 - {1'b0, cnt_q[4:0]};
      end else if (op_q == OP_SHR) begin
         sh_in_d  = rev32(in_q);
      end else if (op_q == OP_SHRA) begin
         sh_in_d  = rev32(neg_d ? ~in_q : in_q);
      end else if (is_rol_d) begin
         sh_cnt_d = {1'b0, cnt_q[4:0]};
      end
   end

   assign sh_out_d = sh_cnt_d[5] ? 32'd0 : (sh_in_d << sh_cnt_d[4:0]);

   always_comb begin
      pass_d = sh_out_d;
      if (second_pass_d || (op_q == OP_SHR) || (op_q == OP_SHRA)) begin
         pass_d = rev32(sh_out_d);
      end
      if (neg_d) begin
         pass_d = ~pass_d;
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         in_q        <= 32'd0;
         cnt_q       <= 6'd0;
         op_q        <= 2'd0;
         res_out_q   <= 32'd0;
         res_id_q    <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  in_q     <= in_d;
                  cnt_q    <= shift_d;
                  op_q     <= op_d;
                  res_id_q <= grant_b_d;
                  last_q   <= grant_b_d;
                  busy_q   <= 1'b1;
                  state_q  <= PASS1;
               end
            end
            PASS1: begin
               // For rotate, this is only the left-shift partial.
               res_out_q <= pass_d;
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
               if (is_rol_d) begin
                  state_q <= PASS2;
               end else begin
                  res_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
`else
               res_valid_q <= 1'b1;
               state_q     <= HOLD;
`endif
            end
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
            PASS2: begin
               res_out_q   <= res_out_q | pass_d;
               res_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
`endif
            HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign res_out   = res_out_q;
   assign res_id    = res_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_shift_scheduler.sv
module tb_alu_shift_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr;
   logic        v    [2];
   logic [31:0] din  [2];
   logic [5:0]  dsh  [2];
   logic [1:0]  dop  [2];
   logic        rdy_a, rdy_b;
   logic        res_valid, res_ready, res_id, busy;
   logic [31:0] res_out;

   int n_chk  = 0;
   int n_pass = 0;
   int last_served = 1;

   alu_shift_scheduler dut (
      .clk         (clk),
      .clr         (clr),
      .req_a_valid (v[0]),
      .req_a_ready (rdy_a),
      .req_a_in    (din[0]),
      .req_a_shift (dsh[0]),
      .req_a_op    (dop[0]),
      .req_b_valid (v[1]),
      .req_b_ready (rdy_b),
      .req_b_in    (din[1]),
      .req_b_shift (dsh[1]),
      .req_b_op    (dop[1]),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_out     (res_out),
      .res_id      (res_id),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference: arithmetic straight from the operation definitions.
   function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [5:0] s,
                                             input logic [1:0] op);
      logic signed [31:0] sx;
      logic [63:0]        dbl;
      sx  = x;
      dbl = 64'd0;
      case (op)
         2'b00:   return (s >= 6'd32) ? 32'd0 : (x << s);
         2'b01:   return (s >= 6'd32) ? 32'd0 : (x >> s);
         2'b10:   return (s >= 6'd32) ? (sx >>> 31) : (sx >>> s);
         default: begin
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
            dbl = {x, x} << s[4:0];
            return dbl[63:32];
`else
            return (s >= 6'd32) ? 32'd0 : (x << s);
`endif
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op);
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
      if (op == 2'b11) return 3;
`endif
      return 2;
   endfunction

   function automatic int pick();
      if (v[0] && v[1]) return (last_served == 0) ? 1 : 0;
      return v[1] ? 1 : 0;
   endfunction

   function automatic logic [5:0] rand_shift();
      case ($urandom_range(0, 5))
         0:       return 6'd0;
         1:       return 6'd31;
         2:       return 6'd32;
         3:       return 6'd63;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   task automatic set_req(input int k, input logic [31:0] x, input logic [5:0] s,
                          input logic [1:0] op);
      v[k]   = 1'b1;
      din[k] = x;
      dsh[k] = s;
      dop[k] = op;
   endtask

   task automatic rand_req(input int k);
      set_req(k, $urandom, rand_shift(), 2'($urandom_range(0, 3)));
   endtask

   // Called at a negedge with the DUT idle and valids driven. Checks the
   // grant, the latency, the result, hold behaviour and the return to idle.
   task automatic serve(input int who, input int hold);
      logic [31:0] exp_out;
      int          exp_lat;
      int          lat;
      #1;
      chk("ready_a", 32'(rdy_a), 32'(who == 0));
      chk("ready_b", 32'(rdy_b), 32'(who == 1));
      exp_out     = ref_shift(din[who], dsh[who], dop[who]);
      exp_lat     = ref_lat(dop[who]);
      last_served = who;
      @(posedge clk);
      @(negedge clk);
      v[who] = 1'b0;
      lat = 1;
      while (res_valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("res_out", res_out, exp_out);
      chk("res_id", 32'(res_id), 32'(who));
      chk("busy_hold", 32'(busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_out", res_out, exp_out);
         chk("hold_id", 32'(res_id), 32'(who));
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_readies", 32'({rdy_a, rdy_b}), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk("valid_drop", 32'(res_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      clr = 1'b0;
      set_req(0, $urandom, rand_shift(), 2'b00);
      set_req(1, $urandom, rand_shift(), 2'b01);
      #1;
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_out", res_out, 32'd0);
      chk("rst_id", 32'(res_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_readies", 32'({rdy_a, rdy_b}), 32'd0);
      repeat (3) @(negedge clk);
      v[0] = 1'b0;
      v[1] = 1'b0;
      clr  = 1'b1;
      last_served = 1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr       = 1'b0;
      res_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         v[k] = 1'b0; din[k] = 32'd0; dsh[k] = 6'd0; dop[k] = 2'd0;
      end
      @(negedge clk);
      do_reset();

      // Basic shift, then the right-shift boundaries on b
      set_req(0, 32'd25, 6'd3, 2'b00);         serve(0, 0);
      set_req(1, 32'h8000_0000, 6'd4, 2'b10);  serve(1, 1);
      set_req(1, 32'h8000_0000, 6'd40, 2'b10); serve(1, 0);
      set_req(1, 32'h8000_0000, 6'd32, 2'b01); serve(1, 0);

      // Contention: a wins after b, then b, then a again
      rand_req(0); rand_req(1); serve(0, 0); serve(1, 0);
      rand_req(0); rand_req(1); serve(0, 0); serve(1, 0);

      // Rotate (or SHL when rotate support is not built)
      set_req(0, 32'h8000_0001, 6'd1, 2'b11);  serve(0, 0);
      set_req(0, 32'h8000_0001, 6'd0, 2'b11);  serve(0, 0);

      // Long hold with the other requester waiting
      rand_req(0); rand_req(1); serve(pick(), 5); serve(pick(), 0);

      // Reset while an operation is in flight
      set_req(0, 32'h8000_0001, 6'd1, 2'b11);
      v[1] = 1'b0;
      #1;
      chk("mid_ready_a", 32'(rdy_a), 32'd1);
      @(posedge clk);
      @(negedge clk);
`ifdef ALU_SHIFT_SCHEDULER_ROTATE_EN
      @(negedge clk);
`endif
      v[0] = 1'b0;
      clr  = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      rand_req(1);
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_quiet", 32'(res_valid), 32'd0);
         chk("mid_rst_ready_b", 32'(rdy_b), 32'd0);
      end
      clr = 1'b1;
      last_served = 1;
      serve(1, 1);

      // Randomized traffic; a waiting requester keeps its request
      for (int it = 0; it < 60; it++) begin
         for (int k = 0; k < 2; k++) begin
            if (!v[k] && $urandom_range(0, 2) != 0) rand_req(k);
         end
         if (!v[0] && !v[1]) rand_req(int'($urandom_range(0, 1)));
         serve(pick(), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
